// File: rtl/cd_config_arbiter.sv
// cd_config_arbiter: round-robin sharing of the clock-divider configuration
// bus between the host UART decoder (requester 0) and the switch/panel
// loader (requester 1). Each granted request produces one c_valid strobe,
// then the divider's ready-low / ready-high handshake is tracked and the
// requester gets an ack pulse, or an err pulse on bad address or timeout.
module cd_config_arbiter #(
  parameter int WIDTH_CONFIG_ADDR = 2,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req0_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] req0_data,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req1_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] req1_data,
  output logic [1:0]                   gnt,
  output logic [1:0]                   ack,
  output logic [1:0]                   err,
  output logic                         busy,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_UART_ready,
  input  logic                         c_VGA_ready
);

  // Timeout counter is at least 8 bits wide, wider if the timeout needs it.
  localparam int CNT_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W    = (CNT_NEED < 8) ? 8 : CNT_NEED;

  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_UART = WIDTH_CONFIG_ADDR'(1);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_VGA  = WIDTH_CONFIG_ADDR'(2);
  localparam logic [CNT_W-1:0]             CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t                       state_reg, state_next;
  logic                         winner_reg, winner_next;   // 0 = req0, 1 = req1
  logic                         rr_reg, rr_next;           // preferred requester on contention
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr_reg, c_addr_next;
  logic [WIDTH_CONFIG_DATA-1:0] c_data_reg, c_data_next;
  logic [CNT_W-1:0]             cnt_reg, cnt_next;

  logic                         pick;
  logic [WIDTH_CONFIG_ADDR-1:0] pick_addr;
  logic [WIDTH_CONFIG_DATA-1:0] pick_data;
  logic                         pick_addr_ok;
  logic                         target_ready;
  logic                         timed_out;
  logic [1:0]                   winner_onehot;

  // Winner selection: a lone request wins outright, contention goes to rr_reg.
  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = rr_reg;
      default: pick = 1'b0;
    endcase
    pick_addr    = pick ? req1_addr : req0_addr;
    pick_data    = pick ? req1_data : req0_data;
    pick_addr_ok = (pick_addr == ADDR_UART) || (pick_addr == ADDR_VGA);
  end

  // The handshake follows only the ready line of the domain actually written.
  assign target_ready  = (c_addr_reg == ADDR_UART) ? c_UART_ready : c_VGA_ready;
  assign timed_out     = (cnt_reg == CNT_LAST);
  assign winner_onehot = winner_reg ? 2'b10 : 2'b01;

  // Next-state logic; bus address/data are only relatched for a valid write,
  // so they keep showing the last issued values while idle.
  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    rr_next     = rr_reg;
    c_addr_next = c_addr_reg;
    c_data_next = c_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          winner_next = pick;
          rr_next     = ~pick;
          if (pick_addr_ok) begin
            c_addr_next = pick_addr;
            c_data_next = pick_data;
            state_next  = ST_ISSUE;
          end else begin
            state_next  = ST_ERR;
          end
        end
      end
      ST_ISSUE:     state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!target_ready)  state_next = ST_WAIT_HIGH;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_WAIT_HIGH: begin
        if (target_ready)   state_next = ST_DONE;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_DONE:      state_next = ST_IDLE;
      ST_ERR:       state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Timeout counter restarts on every state change and runs only while waiting.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg)
      cnt_next = '0;
    else if ((state_reg == ST_WAIT_LOW) || (state_reg == ST_WAIT_HIGH))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      winner_reg <= 1'b0;
      rr_reg     <= 1'b0;
      c_addr_reg <= '0;
      c_data_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      rr_reg     <= rr_next;
      c_addr_reg <= c_addr_next;
      c_data_reg <= c_data_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free
  // and drop to zero the moment reset is asserted.
  always_comb begin
    gnt     = 2'b00;
    ack     = 2'b00;
    err     = 2'b00;
    busy    = (state_reg != ST_IDLE);
    c_valid = (state_reg == ST_ISSUE);
    c_addr  = c_addr_reg;
    c_data  = c_data_reg;
    case (state_reg)
      ST_ISSUE, ST_WAIT_LOW, ST_WAIT_HIGH: gnt = winner_onehot;
      ST_DONE:                             ack = winner_onehot;
      ST_ERR:                              err = winner_onehot;
      default: ;
    endcase
  end

endmodule
